// File: rtl/lfsr_prng_if.sv
// Control/status bundle for lfsr_prng. The generator side uses the slave
// modport; whatever drives the generator uses master.
interface lfsr_prng_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             taps_we;
  logic [WIDTH-1:0] taps_in;
  logic             mode;
  logic [WIDTH-1:0] data_out;
  logic             bit_out;
  logic             wrap;
  logic             lockup;
  logic [WIDTH-1:0] period_out;
  logic             period_valid;

  modport master (
    output en, load, seed_in, taps_we, taps_in, mode,
    input  data_out, bit_out, wrap, lockup, period_out, period_valid
  );

  modport slave (
    input  en, load, seed_in, taps_we, taps_in, mode,
    output data_out, bit_out, wrap, lockup, period_out, period_valid
  );
endinterface

// File: rtl/lfsr_prng.sv
// Run-time configurable LFSR pseudo-random generator.
// Fibonacci or Galois form, loadable seed and taps, STEPS shifts per advance,
// all-zero lock-up recovery and period measurement against the seed register.
module lfsr_prng #(
  parameter int unsigned     WIDTH        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED_RST     = WIDTH'(1),
  parameter int unsigned     STEPS        = 1
) (
  input  logic         clk,
  input  logic         rst,
  lfsr_prng_if.slave   bus
);

  logic [WIDTH-1:0] state_q,  state_d;
  logic [WIDTH-1:0] seed_q,   seed_d;
  logic [WIDTH-1:0] taps_q,   taps_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             pvalid_q, pvalid_d;
  logic             wrap_q,   wrap_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] step_state;
  logic [WIDTH-1:0] cnt_inc;

  // One LFSR shift in the selected form.
  function automatic logic [WIDTH-1:0] shift1(
    input logic [WIDTH-1:0] s,
    input logic [WIDTH-1:0] t,
    input logic             galois
  );
    logic [WIDTH-1:0] r;
    if (galois) begin
      r = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? t : '0);
    end else begin
      r = {s[WIDTH-2:0], ^(s & t)};
    end
    return r;
  endfunction

  // Chain STEPS single shifts; uses the registered (old) taps.
  always_comb begin
    step_state = state_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      step_state = shift1(step_state, taps_q, bus.mode);
    end
  end

  // Saturating increment of the advance counter.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);
  end

  // Next-state selection: load has priority over advance; taps write is independent.
  // An intermediate zero stays zero in either form, so only the final state
  // needs the lock-up check.
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    taps_d   = bus.taps_we ? bus.taps_in : taps_q;

    if (bus.load) begin
      cnt_d    = '0;
      pvalid_d = 1'b0;
      if (bus.seed_in == '0) begin
        state_d  = SEED_RST;
        seed_d   = SEED_RST;
        lockup_d = 1'b1;
      end else begin
        state_d  = bus.seed_in;
        seed_d   = bus.seed_in;
      end
    end else if (bus.en) begin
      if (step_state == '0) begin
        state_d  = SEED_RST;
        seed_d   = SEED_RST;
        cnt_d    = '0;
        lockup_d = 1'b1;
      end else if (step_state == seed_q) begin
        state_d  = step_state;
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        pvalid_d = 1'b1;
        cnt_d    = '0;
      end else begin
        state_d  = step_state;
        cnt_d    = cnt_inc;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED_RST;
      seed_q   <= SEED_RST;
      taps_q   <= DEFAULT_TAPS;
      cnt_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      taps_q   <= taps_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    bus.data_out     = state_q;
    bus.bit_out      = state_q[WIDTH-1];
    bus.wrap         = wrap_q;
    bus.lockup       = lockup_q;
    bus.period_out   = period_q;
    bus.period_valid = pvalid_q;
  end

  // wrap and lockup are mutually exclusive.
  a_flags_exclusive: assert property (@(posedge clk) !(wrap_q && lockup_q));

endmodule

// File: tb/tb_lfsr_prng.sv
module tb_lfsr_prng;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_prng_if #(.WIDTH(4)) b0 ();
  lfsr_prng_if #(.WIDTH(4)) b1 ();

  lfsr_prng #(.WIDTH(4), .DEFAULT_TAPS(4'b1100), .SEED_RST(4'b0001), .STEPS(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  lfsr_prng #(.WIDTH(4), .DEFAULT_TAPS(4'b1100), .SEED_RST(4'b0001), .STEPS(3)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct {
    int         d;
    int         stamp;
    logic [3:0] data;
    logic       wrap;
    logic       lock;
    logic [3:0] per;
    logic       pv;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [3:0] fib  [15] = '{4'h2,4'h4,4'h9,4'h3,4'h6,4'hD,4'hA,4'h5,4'hB,4'h7,4'hF,4'hE,4'hC,4'h8,4'h1};
  logic [3:0] gal  [15] = '{4'h2,4'h4,4'h8,4'h3,4'h6,4'hC,4'hB,4'h5,4'hA,4'h7,4'hE,4'hF,4'hD,4'h9,4'h1};
  logic [3:0] st3  [5]  = '{4'h9,4'hD,4'hB,4'hE,4'h1};

  // Monitor: compare every scoreboard entry due at this cycle.
  logic [3:0] a_data, a_per;
  logic       a_bit, a_wrap, a_lock, a_pv;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (e.stamp < cyc) begin
        n_fail++;
        $display("FAIL %s: entry for cycle %0d missed (now %0d)", e.nm, e.stamp, cyc);
      end else begin
        if (e.d == 0) begin
          a_data = b0.data_out; a_bit = b0.bit_out; a_wrap = b0.wrap;
          a_lock = b0.lockup; a_per = b0.period_out; a_pv = b0.period_valid;
        end else begin
          a_data = b1.data_out; a_bit = b1.bit_out; a_wrap = b1.wrap;
          a_lock = b1.lockup; a_per = b1.period_out; a_pv = b1.period_valid;
        end
        if (a_data !== e.data || a_bit !== e.data[3] || a_wrap !== e.wrap ||
            a_lock !== e.lock || a_per !== e.per || a_pv !== e.pv) begin
          n_fail++;
          $display("FAIL %s (dut%0d cyc %0d): got data=%h bit=%b wrap=%b lock=%b per=%0d pv=%b, want data=%h bit=%b wrap=%b lock=%b per=%0d pv=%b",
                   e.nm, e.d, cyc, a_data, a_bit, a_wrap, a_lock, a_per, a_pv,
                   e.data, e.data[3], e.wrap, e.lock, e.per, e.pv);
        end
      end
    end
  end

  task automatic push(input int d, input logic [3:0] xd, input logic xw, input logic xl,
                      input logic [3:0] xp, input logic xv, input string nm);
    exp_t x;
    x.d = d; x.stamp = cyc + 1; x.data = xd; x.wrap = xw; x.lock = xl;
    x.per = xp; x.pv = xv; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic run(input int d, input logic r, input logic en, input logic ld,
                     input logic [3:0] seed, input logic twe, input logic [3:0] taps,
                     input logic md, input logic [3:0] xd, input logic xw, input logic xl,
                     input logic [3:0] xp, input logic xv, input string nm);
    rst = r;
    b0.en = 0; b0.load = 0; b0.seed_in = 0; b0.taps_we = 0; b0.taps_in = 0; b0.mode = 0;
    b1.en = 0; b1.load = 0; b1.seed_in = 0; b1.taps_we = 0; b1.taps_in = 0; b1.mode = 0;
    if (d == 0) begin
      b0.en = en; b0.load = ld; b0.seed_in = seed; b0.taps_we = twe; b0.taps_in = taps; b0.mode = md;
    end else begin
      b1.en = en; b1.load = ld; b1.seed_in = seed; b1.taps_we = twe; b1.taps_in = taps; b1.mode = md;
    end
    push(d, xd, xw, xl, xp, xv, nm);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values on both instances
    run(0, 1, 0,0,4'h0, 0,4'h0, 0,  4'h1,0,0,4'd0,0, "reset0a");
    push(1, 4'h1,0,0,4'd0,0, "reset1");
    run(0, 1, 1,1,4'h7, 1,4'h3, 0,  4'h1,0,0,4'd0,0, "reset0b");

    // STEPS=3 Fibonacci, taps 1100, seed 1
    run(1, 0, 0,1,4'h1, 1,4'hC, 0,  4'h1,0,0,4'd0,0, "s3_load");
    for (int i = 0; i < 5; i++)
      run(1, 0, 1,0,4'h0, 0,4'h0, 0, st3[i], i==4, 0, (i==4) ? 4'd5 : 4'd0, i==4, "s3_seq");

    // Fibonacci full cycle
    run(0, 0, 0,1,4'h1, 1,4'hC, 0,  4'h1,0,0,4'd0,0, "fib_load");
    for (int i = 0; i < 15; i++)
      run(0, 0, 1,0,4'h0, 0,4'h0, 0, fib[i], i==14, 0, (i==14) ? 4'd15 : 4'd0, i==14, "fib_seq");
    run(0, 0, 0,0,4'h0, 0,4'h0, 0,  4'h1,0,0,4'd15,1, "fib_hold");

    // taps write with advance uses old taps; then zero taps drive lock-up, period_valid kept
    run(0, 0, 1,0,4'h0, 1,4'h0, 0,  4'h2,0,0,4'd15,1, "tw_old_taps");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h4,0,0,4'd15,1, "zt_adv1");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h8,0,0,4'd15,1, "zt_adv2");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h1,0,1,4'd15,1, "lock_adv");
    run(0, 0, 0,0,4'h0, 0,4'h0, 0,  4'h1,0,0,4'd15,1, "lock_clear");

    // Galois full cycle
    run(0, 0, 0,1,4'h1, 1,4'h3, 1,  4'h1,0,0,4'd15,0, "gal_load");
    for (int i = 0; i < 15; i++)
      run(0, 0, 1,0,4'h0, 0,4'h0, 1, gal[i], i==14, 0, 4'd15, i==14, "gal_seq");

    // Zero seed load
    run(0, 0, 0,1,4'h0, 0,4'h0, 0,  4'h1,0,1,4'd15,0, "zero_seed");
    run(0, 0, 0,0,4'h0, 0,4'h0, 0,  4'h1,0,0,4'd15,0, "zero_seed_clr");

    // Zero taps Fibonacci from seed 1: lock-up after WIDTH advances
    run(0, 0, 0,1,4'h1, 1,4'h0, 0,  4'h1,0,0,4'd15,0, "zt_load");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h2,0,0,4'd15,0, "zt2_a1");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h4,0,0,4'd15,0, "zt2_a2");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h8,0,0,4'd15,0, "zt2_a3");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h1,0,1,4'd15,0, "zt2_lock");

    // load+en collision: seed wins, no shift
    run(0, 0, 1,1,4'h5, 1,4'hC, 0,  4'h5,0,0,4'd15,0, "load_en");
    // taps_we+en: old taps 1100 give B, new taps 0011 then give 6
    run(0, 0, 1,0,4'h0, 1,4'h3, 0,  4'hB,0,0,4'd15,0, "tw_en_old");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h6,0,0,4'd15,0, "tw_en_new");
    // mode switch to Galois on the next advance
    run(0, 0, 1,0,4'h0, 0,4'h0, 1,  4'hC,0,0,4'd15,0, "mode_sw");

    // Mid-run reset with en, load and taps_we all asserted
    run(0, 1, 1,1,4'h9, 1,4'h3, 0,  4'h1,0,0,4'd0,0, "mid_rst");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h2,0,0,4'd0,0, "rst_taps1");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h4,0,0,4'd0,0, "rst_taps2");
    run(0, 0, 1,0,4'h0, 0,4'h0, 0,  4'h9,0,0,4'd0,0, "rst_taps3");

    run(0, 0, 0,0,4'h0, 0,4'h0, 0,  4'h9,0,0,4'd0,0, "final_hold");
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d scoreboard entries never checked, want 0", sb.size());
      n_fail += sb.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
- Parametrised pseudo-random sequence generator. Successor to the team's fixed-width Fibonacci LFSR.
- Adds the following over that block:
  - run-time tap polynomial
  - Fibonacci/Galois mode select
  - seed load
  - multiple shifts per cycle
  - lock-up (all-zero) recovery
  - hardware period measurement
- Feeds test-pattern, reaction-timer and random-delay logic in the lab designs.

Parameters:
- WIDTH, 8, state width in bits, legal range 2..32.
- DEFAULT_TAPS, 8'hB8 (WIDTH bits), tap mask loaded at reset.
- SEED_RST, 1 (WIDTH bits, must be non-zero), state and seed value after reset or lock-up recovery.
- STEPS, 1, LFSR shifts applied per advance, legal range 1..WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance the state by STEPS shifts this cycle.
- load  in  1  load seed_in into state and seed register.
- seed_in  in  WIDTH  seed value.
- taps_we  in  1  write taps_in into the tap register.
- taps_in  in  WIDTH  new tap mask.
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled each advance.
- data_out  out  WIDTH  current state.
- bit_out  out  1  state[WIDTH-1].
- wrap  out  1  one-cycle pulse: state returned to the seed register value.
- lockup  out  1  one-cycle pulse: all-zero state trapped and replaced.
- period_out  out  WIDTH  last measured period, in advances.
- period_valid  out  1  period_out holds a measurement since the last load/reset.

Behaviour:
- One clock, rst synchronous active-high. Reset values:
  - state = SEED_RST, seed register = SEED_RST, taps = DEFAULT_TAPS
  - step counter cnt = 0, period_out = 0
  - period_valid, wrap, lockup = 0
- Single-shift functions (S = state, T = taps):
  - Fibonacci: f = XOR-reduce(S & T); next = {S[WIDTH-2:0], f}.
  - Galois: o = S[WIDTH-1]; next = {S[WIDTH-2:0], 0} XOR (o ? T : 0).
- Advance = STEPS chained single shifts, computed combinationally, registered once. Latency 1 cycle from en to data_out.
- Priority each cycle: rst > load > en. taps_we is independent of this priority chain.
- load:
  - state and seed register take seed_in; cnt = 0; period_valid = 0.
  - No advance that cycle even if en = 1.
  - If seed_in == 0: load SEED_RST into both instead and pulse lockup.
- taps_we:
  - The tap register updates at the clock edge.
  - An advance in the same cycle uses the old taps.
- mode: switching takes effect on the next advance; the state is not modified.
- Lock-up: if an advance produces all-zero next state:
  - state and seed register = SEED_RST, cnt = 0
  - lockup pulses the following cycle
  - no wrap; period_valid unchanged
- Period measurement, on each advance:
  - If next state == seed register (checked on final state only when STEPS > 1): pulse wrap, period_out = sat(cnt+1), period_valid = 1, cnt = 0.
  - Otherwise cnt = sat(cnt+1).
  - Saturation limit is 2^WIDTH-1.
- wrap and lockup are registered, high for exactly one cycle, never both in the same cycle.
- en = 0: state, cnt and flags hold; wrap and lockup return to 0.
- rst mid-sequence restores all reset values on the next edge, regardless of load/en/taps_we.

Test Plan:
- Fibonacci cycle: WIDTH=4, taps 4'b1100, mode=0, load 4'b0001, en held.
  - Required sequence: 2,4,9,3,6,D,A,5,B,7,F,E,C,8,1.
  - wrap pulses on the 15th advance; period_out = 15, period_valid = 1.
- Galois cycle: WIDTH=4, taps 4'b0011, mode=1, seed 1.
  - Required sequence: 2,4,8,3,6,C,B,5,A,7,E,F,D,9,1.
  - period_out = 15.
- STEPS=3: WIDTH=4, Fibonacci, taps 4'b1100, seed 1.
  - Required states: 9,D,B,E,1; wrap on the 5th advance; period_out = 5.
- Zero seed / lock-up:
  - load seed_in=0 → data_out = SEED_RST, lockup pulses once.
  - taps=0 Fibonacci run from seed 1 → after WIDTH advances state is reloaded to SEED_RST and lockup pulses.
- Collisions:
  - load+en same cycle → seed loaded, no shift.
  - taps_we+en same cycle → shift uses old taps, the next shift uses new taps.
- Mid-run rst with en=1 and load=1 → next cycle all outputs at reset values, taps = DEFAULT_TAPS.
